alu_cmd_ctrl: RTL
=================

ALU_CMD_CTRL -- requirements
Module: alu_cmd_ctrl

Interface
REQ-001 Parameters SHALL be: IN_WIDTH, 8, operand width; OUT_WIDTH, 16, ALU result width (must equal 2*IN_WIDTH); FUN_WIDTH, 4, function-code width.
REQ-002 CLK  input  1  single clock; all logic on posedge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 RX_P_DATA  input  8  byte from UART receiver, valid when RX_D_VLD=1.
REQ-005 RX_D_VLD  input  1  one-cycle strobe per received byte.
REQ-006 ALU_A  output  IN_WIDTH  operand A to ALU.
REQ-007 ALU_B  output  IN_WIDTH  operand B to ALU.
REQ-008 ALU_FUN  output  FUN_WIDTH  ALU function code.
REQ-009 ALU_EN  output  1  ALU enable, one-cycle pulse per operation.
REQ-010 ALU_OUT  input  OUT_WIDTH  ALU result.
REQ-011 ALU_VALID  input  1  ALU result valid.
REQ-012 TX_P_DATA  output  8  byte to UART transmitter.
REQ-013 TX_D_VLD  output  1  TX byte valid, level until accepted.
REQ-014 TX_BUSY  input  1  transmitter busy.
REQ-015 CMD_ERR  output  1  one-cycle pulse on rejected frame or timeout.

Function
REQ-016 Frame SHALL be three bytes in order: operand A, operand B, function byte; function code = low FUN_WIDTH bits.
REQ-017 States SHALL be IDLE(await A), GET_B, GET_FUN, ALU_REQ, ALU_WAIT, TX_LO, TX_HI.
REQ-018 IDLE->GET_B on RX_D_VLD, capturing ALU_A; GET_B->GET_FUN on RX_D_VLD, capturing ALU_B.
REQ-019 GET_FUN on RX_D_VLD: upper function-byte bits all zero -> capture ALU_FUN, go ALU_REQ; else CMD_ERR pulse next cycle, go IDLE, no ALU_EN.
REQ-020 ALU_EN SHALL be high exactly one cycle (ALU_REQ), the cycle after the function-byte strobe; then ALU_WAIT.
REQ-021 ALU_A/ALU_B/ALU_FUN SHALL remain stable from ALU_REQ until return to IDLE.
REQ-022 ALU_WAIT: on ALU_VALID=1, register ALU_OUT into 16-bit result and go TX_LO.
REQ-023 TX_LO/TX_HI: when TX_BUSY=0 drive TX_P_DATA (result[7:0] then result[15:8]) and TX_D_VLD=1; hold both stable until TX_BUSY sampled 1, then drop TX_D_VLD.
REQ-024 Byte accepted in TX_LO -> TX_HI; accepted in TX_HI -> IDLE; TX_HI SHALL not assert TX_D_VLD until TX_BUSY has returned to 0.
REQ-025 RX_D_VLD in ALU_REQ, ALU_WAIT, TX_LO, TX_HI SHALL be ignored (byte dropped, no error).
REQ-026 ALU_VALID outside ALU_WAIT SHALL be ignored.

Reset
REQ-027 RST=1 SHALL immediately force state IDLE and all outputs (ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, CMD_ERR) and internal registers to 0, from any state.
REQ-028 After RST release, first RX byte SHALL be treated as operand A.

Configuration
REQ-029 Macro ALU_TIMEOUT_EN defined: 4-bit counter in ALU_WAIT; 16 consecutive cycles without ALU_VALID -> CMD_ERR pulse, go IDLE, no TX bytes.
REQ-030 ALU_TIMEOUT_EN undefined: no counter; ALU_WAIT waits indefinitely; CMD_ERR only from REQ-019.

Verification
REQ-031 RX 0x05,0x03,0x00; ALU model returns 0x0008 -> ALU_EN one cycle after third strobe with A=0x05,B=0x03,FUN=0; TX 0x08 then 0x00.
REQ-032 RX 0xFF,0xFF,0x02; result 0xFE01; TX_BUSY held 1 for 20 cycles after first byte -> TX 0x01, TX_HI waits until TX_BUSY=0, then 0xFE.
REQ-033 RX 0x01,0x02,0x1A -> CMD_ERR single pulse, no ALU_EN, IDLE; next frame 0x04,0x02,0x03 -> TX 0x02,0x00.
REQ-034 ALU_VALID never asserted -> with ALU_TIMEOUT_EN CMD_ERR on 16th ALU_WAIT cycle and IDLE; without, state holds ALU_WAIT after 100 cycles.
REQ-035 RST pulsed while TX_D_VLD=1 in TX_HI -> all outputs 0 same cycle; following frame processed normally.
REQ-036 Extra RX byte 0x77 during ALU_WAIT -> ignored; next frame's operand A is the next byte after return to IDLE.

Source files
------------

// File: rtl/alu_cmd_ctrl.sv
// rtl/alu_cmd_ctrl.sv - UART byte-frame command controller driving an ALU and returning its result
//
// Collects a three-byte frame from the UART receiver (operand A, operand B,
// function byte), fires the ALU for one cycle, then waits for the ALU result
// and sends it back to the UART transmitter as two bytes, low byte first.
//
// Ports:
//   CLK        clock, all logic on the rising edge
//   RST        asynchronous active-high reset
//   RX_P_DATA  received byte, valid while RX_D_VLD is high
//   RX_D_VLD   one-cycle strobe per received byte
//   ALU_A      operand A to the ALU
//   ALU_B      operand B to the ALU
//   ALU_FUN    ALU function code (low FUN_WIDTH bits of the function byte)
//   ALU_EN     one-cycle ALU start pulse per accepted frame
//   ALU_OUT    ALU result
//   ALU_VALID  ALU result valid
//   TX_P_DATA  byte to the UART transmitter
//   TX_D_VLD   transmit byte valid, held until the transmitter goes busy
//   TX_BUSY    transmitter busy
//   CMD_ERR    one-cycle pulse on a rejected function byte or an ALU timeout
//
// Build option:
//   ALU_TIMEOUT_EN  when defined, ALU_WAIT gives up after 16 cycles without
//                   ALU_VALID, pulses CMD_ERR and returns to IDLE without
//                   sending anything. When undefined, ALU_WAIT waits forever.

`timescale 1ns/1ps

module alu_cmd_ctrl #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 16,
  parameter int FUN_WIDTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [7:0]           RX_P_DATA,
  input  logic                 RX_D_VLD,
  output logic [IN_WIDTH-1:0]  ALU_A,
  output logic [IN_WIDTH-1:0]  ALU_B,
  output logic [FUN_WIDTH-1:0] ALU_FUN,
  output logic                 ALU_EN,
  input  logic [OUT_WIDTH-1:0] ALU_OUT,
  input  logic                 ALU_VALID,
  output logic [7:0]           TX_P_DATA,
  output logic                 TX_D_VLD,
  input  logic                 TX_BUSY,
  output logic                 CMD_ERR
);

  typedef enum logic [2:0] {
    IDLE,
    GET_B,
    GET_FUN,
    ALU_REQ,
    ALU_WAIT,
    TX_LO,
    TX_HI
  } state_t;

  state_t                 state;
  logic [OUT_WIDTH-1:0]   result;
  logic                   fun_ok;

`ifdef ALU_TIMEOUT_EN
  logic [3:0]             tmo_cnt;
`endif

  // A function byte is only legal when every bit above the function code is zero.
  assign fun_ok = ((RX_P_DATA >> FUN_WIDTH) == 8'd0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      ALU_A     <= '0;
      ALU_B     <= '0;
      ALU_FUN   <= '0;
      ALU_EN    <= 1'b0;
      TX_P_DATA <= '0;
      TX_D_VLD  <= 1'b0;
      CMD_ERR   <= 1'b0;
      result    <= '0;
`ifdef ALU_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      // Both pulses last a single cycle unless re-armed below.
      ALU_EN  <= 1'b0;
      CMD_ERR <= 1'b0;

      case (state)
        IDLE: begin
          if (RX_D_VLD) begin
            ALU_A <= IN_WIDTH'(RX_P_DATA);
            state <= GET_B;
          end
        end

        GET_B: begin
          if (RX_D_VLD) begin
            ALU_B <= IN_WIDTH'(RX_P_DATA);
            state <= GET_FUN;
          end
        end

        GET_FUN: begin
          if (RX_D_VLD) begin
            if (fun_ok) begin
              ALU_FUN <= FUN_WIDTH'(RX_P_DATA);
              // Raised on entry so ALU_EN is high exactly while in ALU_REQ.
              ALU_EN  <= 1'b1;
              state   <= ALU_REQ;
            end else begin
              CMD_ERR <= 1'b1;
              state   <= IDLE;
            end
          end
        end

        ALU_REQ: begin
          state <= ALU_WAIT;
`ifdef ALU_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end

        ALU_WAIT: begin
`ifdef ALU_TIMEOUT_EN
          // tmo_cnt holds the number of completed waiting cycles. CMD_ERR is
          // registered at the end of the 15th so that it is visible during
          // the 16th; once flagged, the frame is abandoned even if the ALU
          // answers in that last cycle.
          if (tmo_cnt == 4'd15) begin
            state <= IDLE;
          end else if (ALU_VALID) begin
            result <= ALU_OUT;
            state  <= TX_LO;
          end else if (tmo_cnt == 4'd14) begin
            CMD_ERR <= 1'b1;
            tmo_cnt <= 4'd15;
          end else begin
            tmo_cnt <= tmo_cnt + 4'd1;
          end
`else
          if (ALU_VALID) begin
            result <= ALU_OUT;
            state  <= TX_LO;
          end
`endif
        end

        // Each TX state has two phases keyed on TX_D_VLD: offer the byte once
        // the transmitter is idle, then hold it until TX_BUSY shows it was taken.
        TX_LO: begin
          if (!TX_D_VLD) begin
            if (!TX_BUSY) begin
              TX_P_DATA <= result[7:0];
              TX_D_VLD  <= 1'b1;
            end
          end else if (TX_BUSY) begin
            TX_D_VLD <= 1'b0;
            state    <= TX_HI;
          end
        end

        // Entered with TX_BUSY high, so the high byte naturally waits for the
        // transmitter to finish the low byte.
        TX_HI: begin
          if (!TX_D_VLD) begin
            if (!TX_BUSY) begin
              TX_P_DATA <= result[15:8];
              TX_D_VLD  <= 1'b1;
            end
          end else if (TX_BUSY) begin
            TX_D_VLD <= 1'b0;
            state    <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
